ram_load_ctrl: RTL and testbench
================================

// Module: ram_load_ctrl
// PURPOSE
//  Front-end controller for the 256x16 block RAM: sole driver of its single R/W port.
//  Serves CPU single-word read/write requests with a req/ack handshake.
//  Also boot-loads RAM from a UART byte stream: count byte, then hi/lo byte pairs.
//  Sits between the CPU bus + UART RX and the RAM; hides the RAM's 1-cycle read latency.
// PARAMETERS
//  ADDR_W   8      RAM word address width (256 words)
//  DATA_W   16     word width; fixed at 16 (two bytes per word)
//  TIMEOUT  50000  max clk cycles between loader bytes before abort (>=2)
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  rst         in   1       synchronous reset, active-high
//  cpu_req     in   1       CPU request; held with addr/we/wdata until cpu_ack
//  cpu_we      in   1       1=write, 0=read
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       1-cycle completion strobe
//  cpu_rdata   out  DATA_W  read data, valid only while cpu_ack=1 on a read
//  rx_data     in   8       UART received byte
//  rx_valid    in   1       1-cycle strobe, rx_data valid
//  load_start  in   1       pulse: enter load mode
//  load_busy   out  1       1 while loader owns RAM
//  load_done   out  1       1-cycle pulse: load completed
//  load_err    out  1       1-cycle pulse: load aborted on byte timeout
//  ram_addr    out  ADDR_W  to RAM addr
//  ram_wdata   out  DATA_W  to RAM wdata
//  ram_rdata   in   DATA_W  from RAM rdata (valid cycle after ram_re edge)
//  ram_ce/ram_we/ram_re out 1  RAM strobes
// BEHAVIOUR
//  Reset: state IDLE; cpu_ack, load_busy, load_done, load_err, ram_ce/we/re = 0;
//   load address, word count, timeout counter, hi-byte reg = 0. Reset mid-op aborts
//   silently (no done/err pulse); a RAM write is issued only outside reset.
//  RAM strobes are combinational from state + inputs; ram_ce = ram_we | ram_re.
//  FSM states: IDLE, RD_ACK, WR_ACK, L_CNT, L_HI, L_LO.
//  IDLE: load_start -> L_CNT (wins over simultaneous cpu_req; req stays pending).
//   else cpu_req&~cpu_we: ram_re=1, ram_addr=cpu_addr -> RD_ACK.
//   else cpu_req&cpu_we: ram_we=1, addr/wdata from CPU (written this edge) -> WR_ACK.
//  RD_ACK: cpu_ack=1, cpu_rdata=ram_rdata -> IDLE. WR_ACK: cpu_ack=1 -> IDLE.
//   Latency: ack 1 cycle after acceptance; new request not accepted in ack cycle,
//   max throughput 1 access / 2 cycles. CPU drops or changes req after ack.
//  Load mode (load_busy=1 in L_*): cpu_req stalls, no ack; load_start ignored.
//   L_CNT: rx_valid -> count = rx_data (0 means 256), load addr = 0 -> L_HI.
//   L_HI: rx_valid -> hi = rx_data -> L_LO.
//   L_LO: rx_valid -> ram_we=1, ram_wdata={hi,rx_data}, ram_addr=load addr;
//    addr+1 (wraps 255->0 only after last word), count-1; count was 1 ->
//    load_done pulse next cycle, IDLE; else L_HI.
//   Timeout counter clears on every rx_valid and on entering L_CNT; reaching
//    TIMEOUT in any L_* -> load_err pulse, IDLE; words already written stay.
//  rx_valid outside L_* ignored. No RAM strobe in any cycle except those above.
// STRUCTURE
//  Shared header comet_mem_defs.vh: FSM state localparams, ADDR_W/DATA_W defaults.
//  One sub-module: load_timeout_cnt (clear, enable -> expire pulse, TIMEOUT param).
//  Remainder is one FSM plus address/count/hi-byte registers.
// TESTING
//  Reset then CPU write 0x12AB@0x05, read 0x05 -> ack 1 cycle after accept, rdata 0x12AB.
//  Back-to-back req held high (write then read 0xFF) -> acks 2 cycles apart, no lost op.
//  load_start, bytes 03,DE,AD,BE,EF,01,23 -> RAM[0..2]=DEAD,BEEF,0123; done 1 pulse.
//  Count byte 00 + 512 bytes -> all 256 words written, addr ends at 0, done once.
//  cpu_req during load -> no ack until load_done, then served correctly.
//  TIMEOUT=10, stop after 3 bytes -> load_err after 10 idle cycles; rst mid-load -> IDLE, no pulse.

Source files
------------

// File: rtl/ram_load_ctrl_pkg.sv
// Shared definitions for the RAM front-end controller: default widths and
// the FSM state encoding.
package ram_load_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ACK = 3'd1;
  localparam logic [2:0] S_WR_ACK = 3'd2;
  localparam logic [2:0] S_L_CNT  = 3'd3;
  localparam logic [2:0] S_L_HI   = 3'd4;
  localparam logic [2:0] S_L_LO   = 3'd5;

  // True in every state where the UART loader owns the RAM.
  function automatic logic is_load_state(input logic [2:0] s);
    return (s == S_L_CNT) || (s == S_L_HI) || (s == S_L_LO);
  endfunction

endpackage

// File: rtl/ram_load_ctrl_timeout_cnt.sv
// Inter-byte timeout for the UART loader. Counts enabled cycles since the
// last clear; expire is asserted combinationally on the TIMEOUT-th
// consecutive enabled, uncleared cycle.
module ram_load_ctrl_timeout_cnt #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expire = enable & ~clear & (cnt == LAST);

  // Idle-cycle counter; restarts on clear and after expiring.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_load_ctrl.sv
// Front-end for the 256x16 block RAM. Sole driver of the RAM port: serves
// CPU single-word accesses (req held until a 1-cycle ack) and boot-loads the
// RAM from a UART byte stream (count byte, then hi/lo pairs per word).
//
// Handshake: cpu_req with cpu_we/cpu_addr/cpu_wdata is held stable by the CPU
// until cpu_ack; the request is accepted in an IDLE cycle, cpu_ack pulses in
// the following cycle (with cpu_rdata for reads), and the CPU must drop or
// change its request after the ack cycle. rx_valid is a 1-cycle strobe with
// no back-pressure.
module ram_load_ctrl
  import ram_load_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              load_start,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              ram_re,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state, nxt;
  logic [ADDR_W-1:0] load_addr;
  logic [8:0]        word_cnt;   // 1..256; a count byte of 0 means 256
  logic [7:0]        hi_byte;
  logic              tmo_expire;
  logic              last_word;

  assign load_busy = is_load_state(state);
  assign cpu_ack   = (state == S_RD_ACK) || (state == S_WR_ACK);
  assign cpu_rdata = (state == S_RD_ACK) ? ram_rdata : '0;
  assign ram_ce    = ram_we | ram_re;
  assign dbg_state = state;
  assign last_word = (state == S_L_LO) && rx_valid && (word_cnt == 9'd1);

  // Timer runs only while loading; any byte or any non-load cycle restarts it,
  // so it is already clear on entry to L_CNT.
  ram_load_ctrl_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid | ~load_busy),
    .enable (load_busy),
    .expire (tmo_expire)
  );

  // Next state and RAM strobes; strobes are suppressed while in reset.
  always_comb begin
    nxt       = state;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          nxt = S_L_CNT;
        end else if (cpu_req) begin
          if (cpu_we) begin
            ram_we = ~rst;
            nxt    = S_WR_ACK;
          end else begin
            ram_re = ~rst;
            nxt    = S_RD_ACK;
          end
        end
      end
      S_RD_ACK, S_WR_ACK: nxt = S_IDLE;
      S_L_CNT: begin
        if (rx_valid)        nxt = S_L_HI;
        else if (tmo_expire) nxt = S_IDLE;
      end
      S_L_HI: begin
        if (rx_valid)        nxt = S_L_LO;
        else if (tmo_expire) nxt = S_IDLE;
      end
      S_L_LO: begin
        if (rx_valid) begin
          ram_we    = ~rst;
          ram_addr  = load_addr;
          ram_wdata = DATA_W'({hi_byte, rx_data});
          nxt       = (word_cnt == 9'd1) ? S_IDLE : S_L_HI;
        end else if (tmo_expire) begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State, loader registers and the registered done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      load_addr <= '0;
      word_cnt  <= '0;
      hi_byte   <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= nxt;
      load_done <= last_word;
      load_err  <= load_busy & tmo_expire;
      if (rx_valid) begin
        case (state)
          S_L_CNT: begin
            word_cnt  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            load_addr <= '0;
          end
          S_L_HI: hi_byte <= rx_data;
          S_L_LO: begin
            load_addr <= load_addr + 1'b1;
            word_cnt  <= word_cnt - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Bench for ram_load_ctrl: behavioural 256x16 RAM with 1-cycle read latency,
// a reference memory image updated from CPU writes and loader byte streams,
// and pulse/strobe monitors.
module tb_ram_load_ctrl;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0, load_start = 1'b0;
  logic        load_busy, load_done, load_err;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_ce, ram_we, ram_re;
  logic [2:0]  dbg_state;

  int total = 0, bad = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
  int wr_cnt = 0, last_wr_addr = -1;

  logic [15:0] ram_model [256];
  logic [15:0] ref_mem   [256];

  ram_load_ctrl #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .rx_data(rx_data),
    .rx_valid(rx_valid), .load_start(load_start), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_re(ram_re), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (ram_we) ram_model[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_model[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (load_done) begin done_cnt++; done_cyc = cyc; end
    if (load_err)  begin err_cnt++;  err_cyc  = cyc; end
    if (ram_we)    begin wr_cnt++;   last_wr_addr = int'(ram_addr); end
    if (ram_ce | ram_we | ram_re | cpu_ack) begin
      chk("ce_is_we_or_re", ram_ce, ram_we | ram_re);
      chk("we_re_exclusive", ram_we & ram_re, 1'b0);
      chk("ack_while_loading", cpu_ack & load_busy, 1'b0);
      chk("strobe_in_reset", ram_ce & rst, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input int bound, output int ack_cyc, output logic [15:0] rd);
    int n = 0;
    logic got = 1'b0;
    ack_cyc = -1;
    rd = '0;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (cpu_ack) begin got = 1'b1; ack_cyc = cyc; rd = cpu_rdata; end
    end
    if (!got) chk("ack_timeout", 1'b0, 1'b1);
  endtask

  // Single CPU access; returns read data and the cycle in which ack appeared.
  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [15:0] d,
                        input int bound, output logic [15:0] rd, output int lat,
                        output int ack_cyc);
    int c0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    c0 = cyc;
    wait_ack(bound, ack_cyc, rd);
    lat = ack_cyc - c0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (we) ref_mem[a] = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load_start();
    @(posedge clk); #1; load_start = 1'b1;
    @(posedge clk); #1; load_start = 0;
  endtask

  // Reference: apply a complete loader stream to the expected image.
  task automatic ref_load(input logic [7:0] bq[$]);
    int n = (bq[0] == 8'd0) ? 256 : int'(bq[0]);
    for (int i = 0; i < n; i++) ref_mem[i] = {bq[1 + 2*i], bq[2 + 2*i]};
  endtask

  task automatic wait_count(input int bound, input int base, input logic is_err);
    int n = 0;
    while (n < bound && (is_err ? err_cnt : done_cnt) == base) begin
      @(negedge clk); n++;
    end
  endtask

  function automatic int image_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (ram_model[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] rd;
    logic [7:0]  bq[$];
    int lat, ac, a1, a2, d0, e0, w0, t_last;
    logic [15:0] wv;

    for (int i = 0; i < 256; i++) begin ram_model[i] = '0; ref_mem[i] = '0; end

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_ce", ram_ce, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", dbg_state, 3'd0);
    chk("post_rst_pulses", {load_done, load_err}, 2'b00);

    // Basic write then read
    cpu_op(1'b1, 8'h05, 16'h12AB, 20, rd, lat, ac);
    chk("wr_latency", lat, 1);
    cpu_op(1'b0, 8'h05, 16'h0000, 20, rd, lat, ac);
    chk("rd_latency", lat, 1);
    chk("rd_data_05", rd, 16'h12AB);

    // Back-to-back with req held high: write then read of 0xFF
    wv = 16'($urandom);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'hFF; cpu_wdata = wv;
    wait_ack(20, a1, rd);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    wait_ack(20, a2, rd);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    ref_mem[8'hFF] = wv;
    chk("b2b_ack_spacing", a2 - a1, 2);
    chk("b2b_rd_data", rd, wv);

    // Short load: 3 words
    d0 = done_cnt;
    bq = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
    pulse_load_start();
    foreach (bq[i]) send_byte(bq[i], $urandom_range(0, 3));
    ref_load(bq);
    wait_count(5, d0, 1'b0);
    @(negedge clk);
    chk("load3_done_once", done_cnt - d0, 1);
    chk("load3_word0", ram_model[0], 16'hDEAD);
    chk("load3_word1", ram_model[1], 16'hBEEF);
    chk("load3_word2", ram_model[2], 16'h0123);
    chk("load3_image", image_diffs(), 0);
    chk("load3_busy_off", load_busy, 0);

    // Full 256-word load via count byte 0
    d0 = done_cnt; w0 = wr_cnt;
    bq = '{8'h00};
    for (int i = 0; i < 512; i++) bq.push_back(8'($urandom));
    pulse_load_start();
    foreach (bq[i]) send_byte(bq[i], $urandom_range(0, 2));
    ref_load(bq);
    wait_count(5, d0, 1'b0);
    repeat (3) @(negedge clk);
    chk("full_done_once", done_cnt - d0, 1);
    chk("full_writes", wr_cnt - w0, 256);
    chk("full_last_addr", last_wr_addr, 255);
    chk("full_image", image_diffs(), 0);

    // CPU read requested in the same cycle as load_start: stalls until done
    d0 = done_cnt;
    bq = '{8'h02, 8'h5A, 8'h5A, 8'hC3, 8'h3C};
    fork
      cpu_op(1'b0, 8'h01, 16'h0000, 400, rd, lat, ac);
      begin
        pulse_load_start();
        foreach (bq[i]) send_byte(bq[i], $urandom_range(0, 3));
      end
    join
    ref_load(bq);
    chk("stall_done_once", done_cnt - d0, 1);
    chk("stall_ack_after_done", ac - done_cyc, 1);
    chk("stall_rd_data", rd, ref_mem[1]);

    // Random CPU traffic
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        cpu_op(1'b1, a, 16'($urandom), 20, rd, lat, ac);
      end else begin
        cpu_op(1'b0, a, 16'h0000, 20, rd, lat, ac);
        chk("rand_rd", rd, ref_mem[a]);
      end
      chk("rand_latency", lat, 1);
    end

    // rx_valid while idle is ignored
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    repeat (2) @(negedge clk);
    chk("idle_rx_no_write", wr_cnt - w0, 0);
    chk("idle_rx_not_busy", load_busy, 0);

    // Timeout: count 5, one full word, then silence
    d0 = done_cnt; e0 = err_cnt;
    pulse_load_start();
    send_byte(8'h05, 1);
    send_byte(8'hAA, 2);
    t_last = cyc;
    send_byte(8'hBB, 0);
    ref_mem[0] = 16'hAABB;
    wait_count(3 * TMO, e0, 1'b1);
    chk("tmo_err_once", err_cnt - e0, 1);
    chk("tmo_err_cycle", err_cyc - t_last, TMO + 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_word_kept", ram_model[0], 16'hAABB);
    @(negedge clk);
    chk("tmo_idle", load_busy, 0);

    // Reset in the middle of a load: silent abort
    d0 = done_cnt; e0 = err_cnt;
    pulse_load_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    send_byte(8'h33, 1);
    ref_mem[0] = 16'h1122;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2 * TMO) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_no_err", err_cnt - e0, 0);
    chk("rst_mid_state", dbg_state, 3'd0);
    cpu_op(1'b0, 8'h00, 16'h0000, 20, rd, lat, ac);
    chk("rst_mid_word0", rd, 16'h1122);
    chk("final_image", image_diffs(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
